// File: rtl/serial_magnitude_comparator.sv
// ---------------------------------------------------------------------------
// serial_magnitude_comparator
//
// Bit-serial magnitude comparator. Two WIDTH-bit operands A and B arrive one
// bit pair per accepted cycle, MSB first. When all pairs have been taken the
// block pulses done and presents a one-hot result, which is held until the
// next start or reset:
//   f1 = A > B, f2 = A == B, f3 = A < B
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   start      in   begin a new comparison (honoured in IDLE and DONE only)
//   bit_valid  in   a_bit/b_bit carry a valid pair this cycle
//   a_bit      in   current bit of A, MSB first
//   b_bit      in   current bit of B, MSB first
//   busy       out  high while collecting bits
//   done       out  one-cycle pulse, f1..f3 hold a fresh result
//   f1/f2/f3   out  registered one-hot result (all 0 while in flight/reset)
//
// Build option
//   SIGNED_CMP_EN  operands are two's complement; a differing sign bit on the
//                  first pair inverts the decision. Undefined: unsigned only.
//
// state | meaning
// ------+-------------------------------------------------------------------
// IDLE  | waiting for start, last result held on f1..f3
// SHIFT | accepting bit pairs, result outputs forced to 0
// DONE  | one cycle, done=1 and f1..f3 valid; start here chains a new compare
// ---------------------------------------------------------------------------
module serial_magnitude_comparator #(
  parameter int WIDTH = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic bit_valid,
  input  logic a_bit,
  input  logic b_bit,
  output logic busy,
  output logic done,
  output logic f1,
  output logic f2,
  output logic f3
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    REL_EQ = 2'd0,
    REL_GT = 2'd1,
    REL_LT = 2'd2
  } rel_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  rel_t            rel_q, rel_d;
  logic [2:0]      res_q, res_d;   // {gt, eq, lt}
  rel_t            rel_step;

  // Map relation to the {f1, f2, f3} encoding.
  function automatic logic [2:0] rel_onehot(input rel_t r);
    logic [2:0] oh;
    oh = 3'b010;
    case (r)
      REL_GT:  oh = 3'b100;
      REL_LT:  oh = 3'b001;
      default: oh = 3'b010;
    endcase
    return oh;
  endfunction

  // ---------------------------------------------------------------------
  // Relation after folding in the current pair. The first differing pair
  // decides; once decided, later bits are consumed without effect.
  // ---------------------------------------------------------------------
  always_comb begin
    rel_step = rel_q;
    if ((rel_q == REL_EQ) && (a_bit != b_bit)) begin
`ifdef SIGNED_CMP_EN
      // Sign bit: a set A sign means A is the negative (smaller) operand.
      if (cnt_q == '0) begin
        rel_step = a_bit ? REL_LT : REL_GT;
      end else begin
        rel_step = a_bit ? REL_GT : REL_LT;
      end
`else
      rel_step = a_bit ? REL_GT : REL_LT;
`endif
    end
  end

  // ---------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      rel_q   <= REL_EQ;
      res_q   <= 3'b000;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rel_q   <= rel_d;
      res_q   <= res_d;
    end
  end

  // ---------------------------------------------------------------------
  // Next-state and datapath update
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rel_d   = rel_q;
    res_d   = res_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_SHIFT;
          cnt_d   = '0;
          rel_d   = REL_EQ;
          res_d   = 3'b000;
        end else if (state_q == ST_DONE) begin
          state_d = ST_IDLE;
        end
      end

      ST_SHIFT: begin
        if (bit_valid) begin
          cnt_d = cnt_q + CW'(1);
          rel_d = rel_step;
          if (cnt_q == CNT_LAST) begin
            // Final pair goes straight into the result register so the
            // answer is visible in the same cycle done is raised.
            state_d = ST_DONE;
            res_d   = rel_onehot(rel_step);
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        rel_d   = REL_EQ;
        res_d   = 3'b000;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  always_comb begin
    busy = (state_q == ST_SHIFT);
    done = (state_q == ST_DONE);
    f1   = res_q[2];
    f2   = res_q[1];
    f3   = res_q[0];
  end

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// ---------------------------------------------------------------------------
// tb_serial_magnitude_comparator
//
// Bench for serial_magnitude_comparator (WIDTH=8). Expected results are
// queued when a comparison is issued; a monitor pops one entry per done
// pulse. Compile with SIGNED_CMP_EN defined for both bench and RTL to cover
// the signed build.
// ---------------------------------------------------------------------------
module tb_serial_magnitude_comparator;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic bit_valid = 1'b0;
  logic a_bit = 1'b0;
  logic b_bit = 1'b0;
  logic busy, done, f1, f2, f3;

  int errors = 0;
  int checks = 0;
  logic [2:0] exp_q[$];
  logic [2:0] last_exp = 3'b000;
  logic prev_done = 1'b0;

  serial_magnitude_comparator #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .bit_valid (bit_valid),
    .a_bit     (a_bit),
    .b_bit     (b_bit),
    .busy      (busy),
    .done      (done),
    .f1        (f1),
    .f2        (f2),
    .f3        (f3)
  );

  always #5 clk = ~clk;

  // Reference: compare the whole operands as numbers. Returns {gt, eq, lt}.
  function automatic logic [2:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
    int sa;
    int sb;
`ifdef SIGNED_CMP_EN
    sa = int'($signed(a));
    sb = int'($signed(b));
`else
    sa = int'(a);
    sb = int'(b);
`endif
    if (sa > sb) return 3'b100;
    if (sa == sb) return 3'b010;
    return 3'b001;
  endfunction

  task automatic chk(input string name, input logic [2:0] act, input logic [2:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: one expected result per done pulse; done never two cycles wide;
  // results stay cleared while a comparison is in flight.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_done = 1'b0;
    end else begin
      if (done) begin
        if (prev_done) begin
          checks++;
          errors++;
          $display("FAIL done_single_cycle: done high two cycles, expected one");
        end
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done with empty queue, expected none");
        end else begin
          chk("result", {f1, f2, f3}, exp_q.pop_front());
        end
      end
      if (busy) chk("f_clear_busy", {f1, f2, f3}, 3'b000);
      prev_done = done;
    end
  end

  // One comparison. Entered and left #1 after a rising edge.
  task automatic run_cmp(input logic [W-1:0] a, input logic [W-1:0] b,
                         input int gap_min, input int gap_max,
                         input bit issue_start, input bit poke_start);
    if (issue_start) begin
      start = 1'b1;
      tick();
      start = 1'b0;
    end
    chk("busy_after_start", {2'b00, busy}, 3'b001);
    chk("f_cleared_after_start", {f1, f2, f3}, 3'b000);
    last_exp = model(a, b);
    exp_q.push_back(last_exp);
    for (int i = W - 1; i >= 0; i--) begin
      int g;
      g = (gap_max > gap_min) ? int'($urandom_range(gap_max, gap_min)) : gap_min;
      for (int k = 0; k < g; k++) begin
        bit_valid = 1'b0;
        a_bit = 1'($urandom);
        b_bit = 1'($urandom);
        start = poke_start;
        tick();
        chk("no_done_in_gap", {2'b00, done}, 3'b000);
      end
      bit_valid = 1'b1;
      a_bit = a[i];
      b_bit = b[i];
      start = poke_start;
      tick();
      if (i > 0) chk("no_early_done", {2'b00, done}, 3'b000);
      else       chk("done_latency", {2'b00, done}, 3'b001);
    end
    bit_valid = 1'b0;
    start = 1'b0;
  endtask

  initial begin
    // 1. reset
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    @(negedge clk);
    chk("reset_busy_done", {1'b0, busy, done}, 3'b000);
    chk("reset_f", {f1, f2, f3}, 3'b000);
    tick();

    // 2. A>B, back-to-back pairs
    run_cmp(8'hA5, 8'h5A, 0, 0, 1'b1, 1'b0);
    tick();
    chk("idle_hold_2", {f1, f2, f3}, last_exp);

    // 3. equal operands, two gap cycles before every pair
    run_cmp(8'h3C, 8'h3C, 2, 2, 1'b1, 1'b0);
    tick();

    // 4. sign bit boundary
    run_cmp(8'h80, 8'h7F, 0, 0, 1'b1, 1'b0);
    tick();

    // 5. reset mid-SHIFT
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = W - 1; i >= W - 3; i--) begin
      bit_valid = 1'b1;
      a_bit = 1'($urandom);
      b_bit = 1'($urandom);
      tick();
    end
    bit_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midreset_busy_done", {1'b0, busy, done}, 3'b000);
    chk("midreset_f", {f1, f2, f3}, 3'b000);
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_reset_no_done", {1'b0, busy, done}, 3'b000);
    run_cmp(8'h00, 8'hFF, 0, 0, 1'b1, 1'b0);
    tick();

    // 6. start while busy ignored, then chained start in the done cycle
    run_cmp(8'h42, 8'h24, 0, 1, 1'b1, 1'b1);
    run_cmp(8'h01, 8'h01, 0, 0, 1'b1, 1'b0);

    // random operands, random gaps, random idle time between compares
    for (int n = 0; n < 30; n++) begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      int idle;
      ra = W'($urandom);
      rb = ($urandom_range(3, 0) == 0) ? ra : W'($urandom);
      idle = int'($urandom_range(2, 0));
      for (int k = 0; k < idle; k++) begin
        tick();
        chk("idle_hold", {f1, f2, f3}, last_exp);
      end
      run_cmp(ra, rb, 0, 2, 1'b1, ($urandom_range(3, 0) == 0));
    end

    repeat (3) tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drained: got %0d pending results, expected 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
